// File: rtl/bs_enc_pkg.sv
// Shared types, constants and helpers for the FM0 / Miller backscatter line encoder.
package bs_enc_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPilot    = 3'd1,
    StPreamble = 3'd2,
    StData     = 3'd3,
    StDummy    = 3'd4,
    StDone     = 3'd5
  } enc_state_e;

  typedef enum logic [1:0] {
    ModeFm0 = 2'b00,
    ModeM2  = 2'b01,
    ModeM4  = 2'b10,
    ModeM8  = 2'b11
  } enc_mode_e;

  // FM0 preamble as half-period pairs, starting from prev_end = 0.
  localparam logic [11:0] FM0_PRE      = 12'b11_01_00_10_01_00;
  // Miller preamble bits, first bit in the MSB.
  localparam logic [5:0]  MIL_PRE      = 6'b010111;
  localparam int unsigned PRE_LEN      = 6;
  localparam int unsigned FM0_VIOL_IDX = 4;

  // Symbol length in BLF cycles for a mode code.
  function automatic logic [3:0] m_of(input logic [1:0] m_sel);
    logic [3:0] m;
    unique case (m_sel)
      2'b00:   m = 4'd1;
      2'b01:   m = 4'd2;
      2'b10:   m = 4'd4;
      default: m = 4'd8;
    endcase
    return m;
  endfunction

  // FM0 preamble data bit at index idx: a data-1 has equal halves. The
  // violation slot decodes as 0 and is flagged separately.
  function automatic logic fm0_pre_bit(input logic [2:0] idx);
    logic [11:0] sh;
    sh = FM0_PRE << {idx, 1'b0};
    return ~(sh[11] ^ sh[10]);
  endfunction

  function automatic logic mil_pre_bit(input logic [2:0] idx);
    logic [5:0] sh;
    sh = MIL_PRE << idx;
    return sh[5];
  endfunction

endpackage

// File: rtl/bs_line_enc_sym_gen.sv
// Per-cycle half-period generator: FM0 (with violation) and Miller rules.
// All inputs describe the symbol cycle that starts at the next posedge.
module bs_sym_gen
  import bs_enc_pkg::*;
(
  input  logic       clk_fm0,
  input  logic       rst_for_new_package,
  input  logic       load,
  input  logic       fm0,
  input  logic       viol,
  input  logic       sym_bit,
  input  logic [2:0] sub_cnt,
  input  logic [2:0] half_m,
  output logic       half_a,
  output logic       half_b
);

  logic half_a_d, half_b_d;
  logic prev_end_q, prev_end_d;
  logic lvl_q, lvl_d;
  logic last_bit_q, last_bit_d;
  logic flip;

  // Next halves and encoder history; history is zeroed whenever no symbol is sent.
  always_comb begin
    half_a_d   = 1'b0;
    half_b_d   = 1'b0;
    prev_end_d = 1'b0;
    lvl_d      = 1'b0;
    last_bit_d = 1'b0;
    flip       = 1'b0;
    if (load) begin
      if (fm0) begin
        if (viol) begin
          half_a_d = prev_end_q;
          half_b_d = ~prev_end_q;
        end else begin
          half_a_d = ~prev_end_q;
          half_b_d = sym_bit ? half_a_d : ~half_a_d;
        end
        prev_end_d = half_b_d;
      end else begin
        // Miller: invert between consecutive zeros, and mid-symbol for a one.
        flip = ((sub_cnt == 3'd0) && !sym_bit && !last_bit_q) ||
               ((sub_cnt == half_m) && sym_bit);
        lvl_d      = lvl_q ^ flip;
        half_a_d   = lvl_d;
        half_b_d   = ~lvl_d;
        last_bit_d = sym_bit;
      end
    end
  end

  // Register halves and history.
  always_ff @(posedge clk_fm0 or negedge rst_for_new_package) begin
    if (!rst_for_new_package) begin
      half_a     <= 1'b0;
      half_b     <= 1'b0;
      prev_end_q <= 1'b0;
      lvl_q      <= 1'b0;
      last_bit_q <= 1'b0;
    end else begin
      half_a     <= half_a_d;
      half_b     <= half_b_d;
      prev_end_q <= prev_end_d;
      lvl_q      <= lvl_d;
      last_bit_q <= last_bit_d;
    end
  end

endmodule

// File: rtl/bs_line_enc.sv
// FM0 / Miller backscatter line encoder: pilot, preamble, payload, dummy-1.
module bs_line_enc
  import bs_enc_pkg::*;
#(
  parameter int unsigned FM0_PILOT   = 12,
  parameter int unsigned MIL_PILOT_S = 4,
  parameter int unsigned MIL_PILOT_L = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic       clk_fm0,
  input  logic       rst_for_new_package,
  input  logic       en_enc,
  input  logic       st_enc,
  input  logic       trext,
  input  logic [1:0] m_sel,
  input  logic       data_valid,
  input  logic       data_bit,
  input  logic       data_last,
  output logic       data_ready,
  output logic       enc_data,
  output logic       enc_complete,
  output logic       enc_underrun
);

  enc_state_e       state_q, state_d;
  logic [2:0]       sub_q, sub_d;
  logic [CNT_W-1:0] sym_q, sym_d;
  logic             trext_q, trext_d;
  logic [1:0]       msel_q, msel_d;
  logic             dbit_q, dbit_d;
  logic             last_q, last_d;
  logic             complete_q, complete_d;
  logic             underrun_q, underrun_d;

  logic [3:0]       m_cur, m_nxt;
  logic             sub_last;
  logic [CNT_W-1:0] pilot_last;
  logic [2:0]       sub_inc;

  logic             gen_load, gen_fm0, gen_viol, gen_bit;
  logic [2:0]       gen_half_m;
  logic             half_a, half_b;

  assign m_cur    = m_of(msel_q);
  assign sub_last = ({1'b0, sub_q} == (m_cur - 4'd1));
  assign sub_inc  = sub_last ? 3'd0 : (sub_q + 3'd1);

  // Index of the final pilot symbol for the captured mode.
  always_comb begin
    pilot_last = '0;
    if (msel_q == ModeFm0) pilot_last = CNT_W'(FM0_PILOT - 1);
    else if (trext_q)      pilot_last = CNT_W'(MIL_PILOT_L - 1);
    else                   pilot_last = CNT_W'(MIL_PILOT_S - 1);
  end

  // Reply sequencing, counters and payload handshake.
  always_comb begin
    state_d    = state_q;
    sub_d      = sub_q;
    sym_d      = sym_q;
    trext_d    = trext_q;
    msel_d     = msel_q;
    dbit_d     = dbit_q;
    last_d     = last_q;
    complete_d = complete_q;
    underrun_d = underrun_q;
    data_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (st_enc && en_enc) begin
          trext_d = trext;
          msel_d  = m_sel;
          sub_d   = 3'd0;
          sym_d   = '0;
          state_d = ((m_sel == ModeFm0) && !trext) ? StPreamble : StPilot;
        end
      end
      StPilot: begin
        sub_d = sub_inc;
        if (sub_last) begin
          if (sym_q == pilot_last) begin
            state_d = StPreamble;
            sym_d   = '0;
          end else begin
            sym_d = sym_q + 1'b1;
          end
        end
      end
      StPreamble: begin
        sub_d = sub_inc;
        if (sub_last) begin
          if (sym_q == CNT_W'(PRE_LEN - 1)) begin
            data_ready = 1'b1;
            sym_d      = '0;
            if (data_valid) begin
              state_d = StData;
              dbit_d  = data_bit;
              last_d  = data_last;
            end else begin
              state_d    = StDummy;
              underrun_d = 1'b1;
            end
          end else begin
            sym_d = sym_q + 1'b1;
          end
        end
      end
      StData: begin
        sub_d = sub_inc;
        if (sub_last) begin
          if (last_q) begin
            state_d = StDummy;
            sym_d   = '0;
          end else begin
            data_ready = 1'b1;
            if (data_valid) begin
              dbit_d = data_bit;
              last_d = data_last;
              sym_d  = sym_q + 1'b1;
            end else begin
              state_d    = StDummy;
              underrun_d = 1'b1;
              sym_d      = '0;
            end
          end
        end
      end
      StDummy: begin
        sub_d = sub_inc;
        if (sub_last) begin
          state_d    = StDone;
          sym_d      = '0;
          complete_d = 1'b1;
        end
      end
      StDone: begin
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Describe the upcoming symbol cycle to the half-period generator.
  assign m_nxt      = m_of(msel_d);
  assign gen_half_m = 3'(m_nxt >> 1);
  assign gen_fm0    = (msel_d == ModeFm0);
  assign gen_load   = (state_d == StPilot) || (state_d == StPreamble) ||
                      (state_d == StData)  || (state_d == StDummy);
  assign gen_viol   = gen_fm0 && (state_d == StPreamble) && (sym_d == CNT_W'(FM0_VIOL_IDX));

  // Bit carried by the upcoming symbol.
  always_comb begin
    gen_bit = 1'b0;
    unique case (state_d)
      StPreamble: gen_bit = gen_fm0 ? fm0_pre_bit(sym_d[2:0]) : mil_pre_bit(sym_d[2:0]);
      StData:     gen_bit = dbit_d;
      StDummy:    gen_bit = 1'b1;
      default:    gen_bit = 1'b0;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_fm0 or negedge rst_for_new_package) begin
    if (!rst_for_new_package) begin
      state_q    <= StIdle;
      sub_q      <= 3'd0;
      sym_q      <= '0;
      trext_q    <= 1'b0;
      msel_q     <= 2'b00;
      dbit_q     <= 1'b0;
      last_q     <= 1'b0;
      complete_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sub_q      <= sub_d;
      sym_q      <= sym_d;
      trext_q    <= trext_d;
      msel_q     <= msel_d;
      dbit_q     <= dbit_d;
      last_q     <= last_d;
      complete_q <= complete_d;
      underrun_q <= underrun_d;
    end
  end

  bs_sym_gen u_sym_gen (
    .clk_fm0             (clk_fm0),
    .rst_for_new_package (rst_for_new_package),
    .load                (gen_load),
    .fm0                 (gen_fm0),
    .viol                (gen_viol),
    .sym_bit             (gen_bit),
    .sub_cnt             (sub_d),
    .half_m              (gen_half_m),
    .half_a              (half_a),
    .half_b              (half_b)
  );

  // High clock phase carries half_a, low phase half_b.
  assign enc_data     = (en_enc && !complete_q) ? (clk_fm0 ? half_a : half_b) : 1'b0;
  assign enc_complete = complete_q;
  assign enc_underrun = underrun_q;

endmodule

// File: tb/tb_bs_line_enc.sv
// Directed bench for bs_line_enc with a half-pair scoreboard built from a reference encoder model.
module tb_bs_line_enc;

  logic       clk_fm0;
  logic       rst_for_new_package;
  logic       en_enc, st_enc, trext;
  logic [1:0] m_sel;
  logic       data_valid, data_bit, data_last;
  logic       data_ready, enc_data, enc_complete, enc_underrun;

  int checks = 0;
  int errors = 0;

  logic       data_bits [16];
  logic [1:0] exp_q [$];
  int         acc_q [$];

  bs_line_enc dut (
    .clk_fm0             (clk_fm0),
    .rst_for_new_package (rst_for_new_package),
    .en_enc              (en_enc),
    .st_enc              (st_enc),
    .trext               (trext),
    .m_sel               (m_sel),
    .data_valid          (data_valid),
    .data_bit            (data_bit),
    .data_last           (data_last),
    .data_ready          (data_ready),
    .enc_data            (enc_data),
    .enc_complete        (enc_complete),
    .enc_underrun        (enc_underrun)
  );

  initial clk_fm0 = 1'b0;
  always #5 clk_fm0 = ~clk_fm0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_fm0);
    rst_for_new_package = 1'b0;
    #2;
    rst_for_new_package = 1'b1;
  endtask

  // Reference encoder: symbol list (2 = FM0 violation) -> expected half-pairs.
  task automatic build_expect(input logic [1:0] mode, input logic tx, input int nb, input int nv);
    int syms [$];
    int npil;
    int m;
    logic pe, lv, prev, a, b;
    int fpre [6] = '{1, 0, 1, 0, 2, 1};
    int mpre [6] = '{0, 1, 0, 1, 1, 1};
    npil = (mode == 2'b00) ? (tx ? 12 : 0) : (tx ? 16 : 4);
    for (int i = 0; i < npil; i++) syms.push_back(0);
    for (int i = 0; i < 6; i++) syms.push_back((mode == 2'b00) ? fpre[i] : mpre[i]);
    for (int i = 0; i < nb && i < nv; i++) syms.push_back(int'(data_bits[i]));
    syms.push_back(1);
    exp_q.delete();
    m = 1 << mode;
    pe = 1'b0; lv = 1'b0; prev = 1'b0;
    foreach (syms[k]) begin
      if (mode == 2'b00) begin
        if (syms[k] == 2) begin
          a = pe; b = ~pe;
        end else begin
          a = ~pe; b = (syms[k] == 1) ? a : ~a;
        end
        pe = b;
        exp_q.push_back({a, b});
      end else begin
        for (int s = 0; s < m; s++) begin
          if (s == 0 && syms[k] == 0 && !prev) lv = ~lv;
          if (s == m / 2 && syms[k] == 1) lv = ~lv;
          exp_q.push_back({lv, ~lv});
        end
        prev = (syms[k] == 1);
      end
    end
  endtask

  // Run one reply: nv bits are offered before data_valid drops; en_enc is low
  // for cycles dis_at..dis_at+2; abort_at>0 returns early after that cycle.
  task automatic run_reply(input logic [1:0] mode, input logic tx, input int nb, input int nv,
                           input int dis_at, input int abort_at);
    int n, idx, nacc;
    logic pend, ha, hb;
    logic [1:0] pair;
    build_expect(mode, tx, nb, nv);
    n = exp_q.size();
    acc_q.delete();
    idx = 0; pend = 1'b0; nacc = 0;
    @(negedge clk_fm0);
    st_enc = 1'b1; en_enc = 1'b1; m_sel = mode; trext = tx;
    data_valid = (nv > 0); data_bit = data_bits[0]; data_last = (nb == 1);
    @(posedge clk_fm0);
    #1;
    st_enc = 1'b0; m_sel = ~mode; trext = ~tx;
    for (int cyc = 1; cyc <= n; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk_fm0);
        #1;
      end
      if (pend) begin
        idx++;
        pend = 1'b0;
        data_valid = (idx < nv) && (idx < nb);
        data_bit   = (idx < 16) ? data_bits[idx] : 1'b0;
        data_last  = (idx == nb - 1);
      end
      if (dis_at > 0 && cyc == dis_at) en_enc = 1'b0;
      if (dis_at > 0 && cyc == dis_at + 3) en_enc = 1'b1;
      #1;
      ha = enc_data;
      @(negedge clk_fm0);
      #2;
      hb = enc_data;
      pair = exp_q.pop_front();
      chk($sformatf("pair m%0d c%0d", mode, cyc), {6'd0, ha, hb}, en_enc ? {6'd0, pair} : 8'd0);
      if (data_ready && data_valid) begin
        pend = 1'b1;
        nacc++;
        acc_q.push_back(cyc);
      end
      if (abort_at == cyc) begin
        exp_q.delete();
        return;
      end
    end
    chk("complete_low_at_end", {7'd0, enc_complete}, 8'd0);
    @(posedge clk_fm0);
    #2;
    chk("complete", {7'd0, enc_complete}, 8'd1);
    chk("underrun", {7'd0, enc_underrun}, {7'd0, (nv < nb)});
    chk("enc_data_done", {7'd0, enc_data}, 8'd0);
    chk("accepted", nacc[7:0], 8'((nv < nb) ? nv : nb));
  endtask

  initial begin
    rst_for_new_package = 1'b0;
    en_enc = 1'b0; st_enc = 1'b0; trext = 1'b0; m_sel = 2'b00;
    data_valid = 1'b0; data_bit = 1'b0; data_last = 1'b0;
    foreach (data_bits[i]) data_bits[i] = 1'b0;
    #1;
    chk("rst_enc_data", {7'd0, enc_data}, 8'd0);
    chk("rst_ready", {7'd0, data_ready}, 8'd0);
    chk("rst_complete", {7'd0, enc_complete}, 8'd0);
    chk("rst_underrun", {7'd0, enc_underrun}, 8'd0);
    @(negedge clk_fm0);
    rst_for_new_package = 1'b1;

    // FM0, no pilot, data 1,0
    data_bits[0] = 1'b1; data_bits[1] = 1'b0;
    run_reply(2'b00, 1'b0, 2, 2, 0, 0);
    chk("acc_count", 8'(acc_q.size()), 8'd2);
    if (acc_q.size() == 2) begin
      chk("acc_cyc0", 8'(acc_q[0]), 8'd6);
      chk("acc_cyc1", 8'(acc_q[1]), 8'd7);
    end
    // st_enc in DONE is ignored
    @(negedge clk_fm0);
    st_enc = 1'b1;
    @(negedge clk_fm0);
    st_enc = 1'b0;
    @(posedge clk_fm0);
    #2;
    chk("done_ignore_hi", {7'd0, enc_data}, 8'd0);
    chk("done_ignore_cmp", {7'd0, enc_complete}, 8'd1);
    @(negedge clk_fm0);
    #2;
    chk("done_ignore_lo", {7'd0, enc_data}, 8'd0);
    chk("done_ready", {7'd0, data_ready}, 8'd0);

    // FM0 with pilot, data 1
    do_reset();
    data_bits[0] = 1'b1;
    run_reply(2'b00, 1'b1, 1, 1, 0, 0);

    // Miller M=4, short pilot, data 0,0
    do_reset();
    data_bits[0] = 1'b0; data_bits[1] = 1'b0;
    run_reply(2'b10, 1'b0, 2, 2, 0, 0);

    // Underrun at the first payload request
    do_reset();
    run_reply(2'b00, 1'b0, 2, 0, 0, 0);

    // Reset in the last preamble cycle of an M=2 reply, then restart
    do_reset();
    data_bits[0] = 1'b1; data_bits[1] = 1'b1; data_bits[2] = 1'b0;
    run_reply(2'b01, 1'b0, 3, 3, 0, 20);
    chk("ready_before_rst", {7'd0, data_ready}, 8'd1);
    rst_for_new_package = 1'b0;
    #1;
    chk("async_enc_data", {7'd0, enc_data}, 8'd0);
    chk("async_ready", {7'd0, data_ready}, 8'd0);
    chk("async_complete", {7'd0, enc_complete}, 8'd0);
    chk("async_underrun", {7'd0, enc_underrun}, 8'd0);
    @(posedge clk_fm0);
    #1;
    chk("async_hold_data", {7'd0, enc_data}, 8'd0);
    #1;
    rst_for_new_package = 1'b1;
    run_reply(2'b01, 1'b0, 3, 3, 0, 0);

    // en_enc low for three cycles mid-DATA
    do_reset();
    data_bits[0] = 1'b1; data_bits[1] = 1'b0; data_bits[2] = 1'b0;
    data_bits[3] = 1'b1; data_bits[4] = 1'b1; data_bits[5] = 1'b0;
    run_reply(2'b00, 1'b1, 6, 6, 20, 0);

    // Miller M=8, long pilot, data 1,0,1
    do_reset();
    data_bits[0] = 1'b1; data_bits[1] = 1'b0; data_bits[2] = 1'b1;
    run_reply(2'b11, 1'b1, 3, 3, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bs_line_enc.md
Name: bs_line_enc

Overview:
- Parametrised successor to the single-mode FM0 backscatter encoder.
- Encodes the tag reply bit stream as FM0 or as Miller M=2/4/8, selected per reply.
- Generates the pilot tone (TRext), the preamble and the end-of-signalling dummy-1 itself, and pulls data through a ready/valid handshake.
- Sits between the reply framer and the modulator; runs at one clk_fm0 cycle per BLF period.

Parameters:
- FM0_PILOT, 12: number of FM0 data-0 pilot symbols when trext=1.
- MIL_PILOT_S, 4: number of Miller pilot symbols when trext=0.
- MIL_PILOT_L, 16: number of Miller pilot symbols when trext=1.
- CNT_W, 5: width of the symbol counter; must hold max(FM0_PILOT, MIL_PILOT_L, 6).

Ports:
- clk_fm0  in  1  BLF clock.
- rst_for_new_package  in  1  reset, asynchronous, active-low.
- en_enc  in  1  encoder enable; gates enc_data.
- st_enc  in  1  start strobe, sampled in IDLE.
- trext  in  1  pilot length select, captured at start.
- m_sel  in  2  mode: 00 FM0, 01 M2, 10 M4, 11 M8; captured at start.
- data_valid  in  1  payload bit valid.
- data_bit  in  1  payload bit.
- data_last  in  1  marks the final payload bit.
- data_ready  out  1  payload bit accepted this posedge when data_valid=1.
- enc_data  out  1  encoded baseband waveform.
- enc_complete  out  1  reply finished; sticky.
- enc_underrun  out  1  data_valid was low when a bit was required; sticky.

Behaviour:
- Reset values: all state and counters 0; IDLE; enc_data=0, enc_complete=0, enc_underrun=0, data_ready=0, half_a=half_b=0, prev_end=0, miller level b=0.
- Half-symbol output: half_a and half_b are registered on posedge.
  - enc_data = (en_enc & ~enc_complete) ? (clk_fm0 ? half_a : half_b) : 0.
  - Each clk_fm0 cycle therefore carries two half-periods with no 2xBLF clock.
  - In IDLE, and in DONE, half_a = half_b = 0.
- FM0 symbol, one cycle, bit d:
  - half_a = ~prev_end; half_b = d ? half_a : ~half_a; prev_end <= half_b.
- FM0 violation symbol v: half_a = prev_end; half_b = ~prev_end.
- Miller symbol, M cycles:
  - At sub_cnt=0, b inverts if the current bit and the previous bit are both 0.
  - At sub_cnt=M/2, b inverts if the current bit is 1.
  - Every cycle: half_a = b, half_b = ~b.
  - The previous bit is 0 at start of reply.
- States: IDLE, PILOT, PREAMBLE, DATA, DUMMY, DONE.
- IDLE:
  - st_enc & en_enc at posedge: capture trext and m_sel; clear sub_cnt and sym_cnt.
  - Go to PILOT, or to PREAMBLE when FM0 & trext=0.
  - The first symbol is output in the following cycle.
- PILOT:
  - Sends data-0 symbols: FM0_PILOT in FM0; MIL_PILOT_L or MIL_PILOT_S in Miller depending on trext.
  - Goes to PREAMBLE after the last cycle of the last pilot symbol.
- PREAMBLE:
  - FM0: the 6 symbols 1,0,1,0,v,1.
  - Miller: bits 0,1,0,1,1,1 under normal Miller rules.
- data_ready:
  - Combinationally 1 in the last cycle of the last preamble symbol and in the last cycle of every DATA symbol.
  - Last cycle means sub_cnt = M-1; M = 1 for FM0.
  - A bit accepted at that posedge is the next symbol.
  - data_ready = 0 in all other cycles, including the last cycle of the data_last symbol.
- DATA:
  - The symbol whose bit had data_last=1 is followed by DUMMY.
  - If data_ready=1 and data_valid=0: set enc_underrun, go to DUMMY.
- DUMMY: one data-1 symbol, then DONE.
- DONE:
  - enc_complete=1 from the posedge ending the dummy symbol until reset.
  - st_enc is ignored.
- Counters:
  - sub_cnt wraps modulo M.
  - sym_cnt clears on every state change.
  - Unsigned arithmetic, no saturation required.
- Boundary conditions:
  - st_enc outside IDLE is ignored.
  - en_enc low mid-reply: the state machine continues and enc_data is forced 0.
  - Reset mid-reply returns to the reset values within the same instant, asynchronously.
  - m_sel and trext changes after start have no effect.

Decomposition:
- Package bs_enc_pkg:
  - state encoding;
  - mode codes;
  - FM0_PRE = 12'b11_01_00_10_01_00 (half-pair reference when prev_end=0);
  - MIL_PRE = 6'b010111;
  - function m_of(m_sel) returning 1/2/4/8.
- One sub-module, bs_sym_gen: the per-cycle half_a/half_b generator (FM0/violation/Miller rules, prev_end, b).
- The top holds the FSM, counters and handshake.

Test Plan:
- FM0, trext=0, data 1 then 0 (last):
  - Half-pairs are 11 01 00 10 01 00 | 11 01 | 00.
  - enc_complete rises at the posedge ending cycle 9 after start.
  - Bits are accepted at the ends of cycles 6 and 7.
- FM0, trext=1, data 1 (last): 12 pilot cycles alternating 10,10,..., then the preamble, then data and dummy; total 12+6+1+1 = 20 cycles.
- Miller M=4, trext=0, data 0,0 (last): 16 pilot + 24 preamble + 8 data + 4 dummy = 52 cycles.
  - Each cycle half_b = ~half_a.
  - b inverts at the start of the second data-0.
- Underrun: FM0 with data_valid held 0 at the first data_ready cycle → enc_underrun=1, dummy-1 sent, enc_complete one cycle later.
- Reset asserted during PREAMBLE → all outputs 0 immediately; a new st_enc restarts from the pilot.
- en_enc deasserted for 3 cycles mid-DATA → enc_data=0 in those cycles; the symbol count is unaffected and enc_complete timing is unchanged.
